// File: rtl/npc_mem_arbiter_pkg.sv
// Shared types for the NPC data-memory arbiter: FSM states, owner encoding
// and the store-mask width used on every port.
package npc_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  typedef enum logic       {OWN_IFU, OWN_LSU}      arb_owner_t;

  localparam int WMASK_W = 8;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// One request/response channel. The requester side is the master; the arbiter
// is a slave towards IFU/LSU and a master towards the memory block.
interface npc_mem_arbiter_if
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic               valid;
  logic               ready;
  logic               wen;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic [WMASK_W-1:0] wmask;
  logic               rvalid;
  logic [DATA_W-1:0]  rdata;
  logic               err;

  modport master (output valid, wen, addr, wdata, wmask,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  valid, wen, addr, wdata, wmask,
                  output ready, rvalid, rdata, err);

endinterface

// File: rtl/npc_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last
// wins; a lone requester always wins.
module npc_rr_arb2
  import npc_mem_pkg::*;
(
  input  logic       req_ifu,
  input  logic       req_lsu,
  input  arb_owner_t last_grant,
  output logic       gnt_ifu,
  output logic       gnt_lsu
);

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (req_ifu && req_lsu) begin
      gnt_ifu = (other_owner(last_grant) == OWN_IFU);
      gnt_lsu = (other_owner(last_grant) == OWN_LSU);
    end else begin
      gnt_ifu = req_ifu;
      gnt_lsu = req_lsu;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares the single NPC data-memory port between IFU and LSU, one transaction
// in flight at a time, with a watchdog that turns a lost response into an error.
module npc_mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  npc_mem_arbiter_if.slave    ifu,
  npc_mem_arbiter_if.slave    lsu,
  npc_mem_arbiter_if.master   mem
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t         state;
  arb_owner_t         owner_q;
  arb_owner_t         last_grant;
  logic [WD_W-1:0]    wd_cnt;

  logic [ADDR_W-1:0]  addr_q;
  logic               wen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [WMASK_W-1:0] wmask_q;

  logic               ifu_rvalid_q, lsu_rvalid_q;
  logic [DATA_W-1:0]  ifu_rdata_q,  lsu_rdata_q;
  logic               ifu_err_q,    lsu_err_q;

  logic gnt_ifu, gnt_lsu;
  logic idle;
  logic rsp_done, rsp_err;

  npc_rr_arb2 u_rr (
    .req_ifu    (ifu.valid),
    .req_lsu    (lsu.valid),
    .last_grant (last_grant),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  // rst_n gates ready so every output is 0 while reset is held
  assign idle      = (state == IDLE) && rst_n;
  assign ifu.ready = idle && gnt_ifu;
  assign lsu.ready = idle && gnt_lsu;

  assign ifu.rvalid = ifu_rvalid_q;
  assign ifu.rdata  = ifu_rdata_q;
  assign ifu.err    = ifu_err_q;
  assign lsu.rvalid = lsu_rvalid_q;
  assign lsu.rdata  = lsu_rdata_q;
  assign lsu.err    = lsu_err_q;

  // mem_valid is a pure state decode, so it falls the moment reset asserts
  assign mem.valid = (state == REQ);
  assign mem.wen   = wen_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.wmask = wmask_q;

  // a response present in the timeout cycle takes priority over the error
  assign rsp_done = mem.rvalid || (wd_cnt == WD_W'(TIMEOUT - 1));
  assign rsp_err  = !mem.rvalid;

  logic unused_ok;
  assign unused_ok = ^{mem.err, ifu.wen, ifu.wdata, ifu.wmask};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant   <= OWN_LSU;
      wd_cnt       <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      ifu_err_q    <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_err_q    <= 1'b0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      ifu_err_q    <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (ifu.ready) begin
            owner_q    <= OWN_IFU;
            last_grant <= OWN_IFU;
            addr_q     <= ifu.addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            state      <= REQ;
          end else if (lsu.ready) begin
            owner_q    <= OWN_LSU;
            last_grant <= OWN_LSU;
            addr_q     <= lsu.addr;
            wen_q      <= lsu.wen;
            wdata_q    <= lsu.wdata;
            wmask_q    <= lsu.wen ? lsu.wmask : '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem.ready) begin
            wd_cnt <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_done) begin
            state <= RESP;
            if (owner_q == OWN_IFU) begin
              ifu_rvalid_q <= 1'b1;
              ifu_rdata_q  <= rsp_err ? '0 : mem.rdata;
              ifu_err_q    <= rsp_err;
            end else begin
              lsu_rvalid_q <= 1'b1;
              lsu_rdata_q  <= (rsp_err || wen_q) ? '0 : mem.rdata;
              lsu_err_q    <= rsp_err;
            end
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
